// File: rtl/program_loader.sv
// Streams a length-prefixed, big-endian word image into program memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the load is accepted.
module program_loader #(
    parameter int          MEMORY_DEPTH = 100,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] DEPTH_32 = 32'(MEMORY_DEPTH);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINISH_STATE = CSUM;
`else
    localparam state_t FINISH_STATE = DONE;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_len;
    logic [31:0] r_index;
    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic [31:0] w_index_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign byte_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA)
`ifdef LOADER_CHECKSUM_EN
                        || (r_state == CSUM)
`endif
                        ;
    assign w_accept    = byte_valid && byte_ready;
    assign w_len_full  = {r_len[15:8], byte_data};
    assign w_index_inc = r_index + 32'd1;

    assign mem_we    = (r_state == WRITE);
    assign mem_addr  = BASE_ADDRESS + (r_index << 2);
    assign mem_wdata = r_word;
    assign cpu_reset = (r_state != DONE);
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERROR);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_accept) w_state_next = LEN_LO;
            end
            LEN_LO: begin
                // The depth check here is what keeps every write address inside the memory.
                if (w_accept) begin
                    if (w_len_full == 16'd0)
                        w_state_next = FINISH_STATE;
                    else if ({16'd0, w_len_full} > DEPTH_32)
                        w_state_next = ERROR;
                    else
                        w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = WRITE;
            end
            WRITE: begin
                if (w_index_inc == {16'd0, r_len})
                    w_state_next = FINISH_STATE;
                else
                    w_state_next = DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_accept) w_state_next = (byte_data == r_csum) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) w_state_next = LEN_HI;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= 16'd0;
            r_index    <= 32'd0;
            r_word     <= 32'd0;
            r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_index    <= 32'd0;
                        r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                LEN_HI: begin
                    if (w_accept) r_len[15:8] <= byte_data;
                end
                LEN_LO: begin
                    if (w_accept) r_len[7:0] <= byte_data;
                end
                DATA: begin
                    // The byte counter wraps to zero on the 4th byte, ready for the next word.
                    if (w_accept) begin
                        r_word     <= {r_word[23:0], byte_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ byte_data;
`endif
                    end
                end
                WRITE: begin
                    r_index <= w_index_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a reference model queues expected writes/status,
// and a negedge monitor checks each mem_we pulse and its timing against that queue.
module tb_program_loader;

    localparam int          DEPTH = 100;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    program_loader #(
        .MEMORY_DEPTH(DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the model queue and obey the write timing.
    logic prev_we = 1'b0;
    logic prev_acc = 1'b0;
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
            end else begin
                check("write_addr", mem_addr, exp_addr_q.pop_front());
                check("write_data", mem_wdata, exp_data_q.pop_front());
            end
            check("ready_low_in_write", byte_ready, 1'b0);
            check("write_follows_accept", prev_acc, 1'b1);
            check("we_single_cycle", prev_we, 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        if (prev_we && !reset) check("ready_after_write", byte_ready, 1'b1);
`else
        if (prev_we && !reset && exp_addr_q.size() != 0) check("ready_after_write", byte_ready, 1'b1);
`endif
        prev_we  = mem_we;
        prev_acc = byte_valid && byte_ready;
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int  t;
        bit  got;
        if (stall) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        got = 1'b0;
        t = 0;
        while (!got && t < 100) begin
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (byte_ready) got = 1'b1;
            else t++;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: got byte_ready=0 expected 1 within 100 cycles");
        end else begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        start      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_cpu_reset", cpu_reset, 1'b1);
        check("start_done_clear", done, 1'b0);
        check("start_error_clear", error, 1'b0);
    endtask

    task automatic wait_status(input bit exp_done, input bit exp_err);
        int t = 0;
        @(negedge clk);
        while (!done && !error && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("status_done", done, exp_done);
        check("status_error", error, exp_err);
        check("status_cpu_reset", cpu_reset, !exp_done);
        check("writes_outstanding", exp_addr_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Reference model: words go to BASE+4*i, big-endian; length above DEPTH is an error.
    task automatic run_words(input logic [15:0] n, input logic [31:0] words[$], input bit stall, input bit bad_csum);
        logic [7:0] x;
        logic [31:0] w;
        x = 8'h00;
        do_start();
        send_byte(n[15:8], stall);
        send_byte(n[7:0], stall);
        if (32'(n) > DEPTH) begin
            wait_status(1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_data_q.push_back(w);
            for (int j = 0; j < 4; j++) begin
                x = x ^ w[31 - 8 * j -: 8];
                send_byte(w[31 - 8 * j -: 8], stall);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (x ^ 8'h5A) : x, stall);
        wait_status(!bad_csum, bad_csum);
`else
        wait_status(1'b1, 1'b0);
`endif
    endtask

    task automatic run_load(input logic [15:0] n, input bit stall, input bit bad_csum);
        logic [31:0] words[$];
        int cnt;
        cnt = (32'(n) > DEPTH) ? 0 : int'(n);
        for (int i = 0; i < cnt; i++) words.push_back($urandom);
        run_words(n, words, stall, bad_csum);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] vec[$];
        logic [15:0] n;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_ready", byte_ready, 1'b0);
        $display("txn: reset state checked");

        vec = '{32'h2008_0005, 32'h2009_0007};
        run_words(16'd2, vec, 1'b1, 1'b0);
        $display("txn: directed two-word load");

        run_load(16'h0065, 1'b1, 1'b0);
        $display("txn: oversize length 0x0065");

        run_load(16'd0, 1'b1, 1'b0);
        $display("txn: zero-length load");

        run_load(16'd1, 1'b0, 1'b0);
        $display("txn: one-word load, continuous valid");

        run_load(16'(DEPTH), 1'b0, 1'b0);
        $display("txn: full-depth load");

        do_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("midword_reset");
        run_load(16'd2, 1'b1, 1'b0);
        $display("txn: reset mid-word then reload");

`ifdef LOADER_CHECKSUM_EN
        run_load(16'd3, 1'b1, 1'b1);
        $display("txn: bad checksum");
        run_load(16'd3, 1'b1, 1'b0);
        $display("txn: good checksum after error");
`endif

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 4) == 0) n = 16'($urandom_range(DEPTH + 1, 65535));
            else n = 16'($urandom_range(0, 6));
            run_load(n, 1'($urandom_range(0, 1)), 1'b0);
            $display("txn: random load n=%0d", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
